decode_stage: RTL

- Pipeline stage directly upstream of the execute-stage immediate extender.
- Accepts fetched instructions (pc, raw_instr) over a valid/ready handshake and classifies each by opcode into the instruction format.
- Extracts register indices, flags illegal opcodes, and presents a registered decoded bundle to execute.
- Contains a 2-entry skid buffer, so upstream ready is fully registered and does not depend combinationally on out_ready.

---
 rtl/decode_stage_pkg.sv | 63 ++++++
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage_decoder_comb.sv | 34 +++
 rtl/decode_stage.sv | 92 +++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared pipeline types for the decode stage and its neighbours.
//   u32 / u64   : instruction word / program counter types
//   type_t      : instruction format classes (I/U/S/B/J/R, N = not recognised)
//   OP_*        : major opcode values, raw[6:0]
//   decoded_t   : bundle handed from decode to execute
package decode_stage_pkg;

  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    U_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    J_TYPE = 3'd4,
    R_TYPE = 3'd5,
    N_TYPE = 3'd6
  } type_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP32     = 7'b0111011;

  typedef struct packed {
    u64         pc;
    u32         raw_instr;
    type_t      typ;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } decoded_t;

  // Idle value of a bundle register: all zero, format N, not flagged illegal.
  localparam decoded_t DECODED_RST = '{
    pc: '0, raw_instr: '0, typ: N_TYPE, rs1: '0, rs2: '0, rd: '0, illegal: 1'b0
  };

  function automatic type_t op_type(input logic [6:0] op);
    type_t t;
    case (op)
      OP_IMM, OP_IMM32, LOAD, JALR, SYSTEM: t = I_TYPE;
      LUI, AUIPC:                           t = U_TYPE;
      STORE:                                t = S_TYPE;
      BRANCH:                               t = B_TYPE;
      JAL:                                  t = J_TYPE;
      OP, OP32:                             t = R_TYPE;
      default:                              t = N_TYPE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle.
//   in_*   : fetch side (valid/ready, pc, raw word) plus flush redirect
//   out_*  : decoded bundle to execute (valid/ready + decoded fields)
// Modport slave is the decode stage; master is whoever drives fetch and
// consumes the execute side.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic       in_valid;
  logic       in_ready;
  u64         in_pc;
  u32         in_raw_instr;
  logic       flush;

  logic       out_valid;
  logic       out_ready;
  u64         out_pc;
  u32         out_raw_instr;
  type_t      out_typ;
  logic [4:0] out_rs1;
  logic [4:0] out_rs2;
  logic [4:0] out_rd;
  logic       out_illegal;

  modport slave (
    input  in_valid, in_pc, in_raw_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_raw_instr, out_typ,
           out_rs1, out_rs2, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_raw_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_raw_instr, out_typ,
           out_rs1, out_rs2, out_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage_decoder_comb.sv
// Purely combinational instruction classifier.
//   pc, raw : incoming instruction
//   dec     : decoded bundle; register fields a format does not use read 0
module decoder_comb
  import decode_stage_pkg::*;
(
  input  u64       pc,
  input  u32       raw,
  output decoded_t dec
);

  type_t      typ;
  logic [4:0] rs1, rs2, rd;

  always_comb begin
    typ = op_type(raw[6:0]);
    rd  = raw[11:7];
    rs1 = raw[19:15];
    rs2 = raw[24:20];
    case (typ)
      I_TYPE:         rs2 = '0;
      U_TYPE, J_TYPE: begin rs1 = '0; rs2 = '0; end
      S_TYPE, B_TYPE: rd  = '0;
      R_TYPE:         ;
      default:        begin rs1 = '0; rs2 = '0; rd = '0; end
    endcase
  end

  assign dec = '{
    pc: pc, raw_instr: raw, typ: typ, rs1: rs1, rs2: rs2, rd: rd,
    illegal: (typ == N_TYPE)
  };

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage with a 2-entry (main + skid) buffer.
//   clk, reset : clock, async active-low reset
//   ifc        : decode_stage_if.slave; fetch handshake in, decoded bundle out
// in_ready is a flop, so fetch never sees a combinational path from
// out_ready. The skid entry absorbs the one instruction that can arrive in
// the cycle after execute stalls.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  ifc
);

  decoded_t dec;
  decoded_t main_q, main_d;
  decoded_t skid_q, skid_d;
  logic     main_vld_q, main_vld_d;
  logic     skid_vld_q, skid_vld_d;
  logic     in_ready_q, in_ready_d;
  logic     acc, cons;

  decoder_comb u_dec (
    .pc  (ifc.in_pc),
    .raw (ifc.in_raw_instr),
    .dec (dec)
  );

  assign acc  = ifc.in_valid && in_ready_q;
  assign cons = main_vld_q && ifc.out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;

    if (ifc.flush) begin
      // Redirect: drop everything, including an input arriving this cycle.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (cons) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = 1'b0;
        end
      end
      // With skid full in_ready is low, so acc never races the skid refill.
      if (acc) begin
        if (!main_vld_q || (cons && !skid_vld_q)) begin
          main_d     = dec;
          main_vld_d = 1'b1;
        end else begin
          skid_d     = dec;
          skid_vld_d = 1'b1;
        end
      end
    end

    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q     <= DECODED_RST;
      skid_q     <= DECODED_RST;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign ifc.in_ready      = in_ready_q;
  assign ifc.out_valid     = main_vld_q;
  assign ifc.out_pc        = main_q.pc;
  assign ifc.out_raw_instr = main_q.raw_instr;
  assign ifc.out_typ       = main_q.typ;
  assign ifc.out_rs1       = main_q.rs1;
  assign ifc.out_rs2       = main_q.rs2;
  assign ifc.out_rd        = main_q.rd;
  assign ifc.out_illegal   = main_q.illegal;

endmodule
